bp_mmu_fill_sched: RTL and testbench

Shares one page-table walker between the instruction-side and data-side MMUs. Accepts TLB-miss requests from both, arbitrates round-robin, issues one walk at a time, and routes the resulting leaf PTE back as a single-cycle TLB write (`w_v_i`/`w_vtag_i`/`w_entry_i`) to the requesting MMU. A page-fault indication is routed back instead when the walk faults. Sits between the two MMUs and the PTW in the core.

---
 rtl/bp_mmu_fill_sched.sv | 215 +++++++++++++++++++++
 tb/tb_bp_mmu_fill_sched.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_mmu_fill_sched.sv
// -----------------------------------------------------------------------------
// bp_mmu_fill_sched
//
// Shares one page-table walker between the instruction-side and data-side
// MMUs. TLB-miss requests from both sides are arbitrated round-robin. One walk
// is in flight at a time, and the leaf PTE that comes back is returned as a
// single-cycle TLB write strobe to the MMU that asked for it. If the walk
// faulted, a fault strobe is returned to that MMU instead.
//
// Optional feature macro: BP_MMU_FILL_DEDUP_EN
//   When defined, simultaneous I/D misses to the same vtag are merged into a
//   single walk and both sides are filled (or faulted) together.
//
// Ports
//   clk_i          clock
//   reset_n_i      asynchronous active-low reset
//   flush_i        sfence / satp change; poisons any walk in flight
//   miss_v_i[1:0]  miss request valid, [0]=I-side, [1]=D-side
//   miss_vtag_i    {D vtag, I vtag}
//   miss_ready_o   request accepted this cycle when v & ready
//   walk_v_o       walk request valid to PTW
//   walk_vtag_o    vtag to walk
//   walk_ready_i   PTW accepts walk
//   walk_done_v_i  walk result valid (one cycle)
//   walk_entry_i   leaf PTE
//   walk_fault_i   walk page-faulted, qualified by walk_done_v_i
//   fill_v_o[1:0]  TLB write strobe per requester
//   fill_vtag_o    TLB write vtag
//   fill_entry_o   TLB write entry
//   fault_v_o[1:0] walk-fault notification per requester
//   dbg_state_o    current FSM state (IDLE=0, REQ=1, WAIT=2, FILL=3)
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. On the miss side ready is a combinational function of the
// request valids and vtags. On the walk side walk_v_o and walk_vtag_o are held
// stable from assertion until walk_ready_i is seen; the walk is never
// withdrawn. walk_done_v_i is a single-cycle pulse with no back-pressure.
// -----------------------------------------------------------------------------
module bp_mmu_fill_sched #(
  parameter int vtag_width_p  = 27,
  parameter int entry_width_p = 36
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        flush_i,
  input  logic [1:0]                  miss_v_i,
  input  logic [2*vtag_width_p-1:0]   miss_vtag_i,
  output logic [1:0]                  miss_ready_o,
  output logic                        walk_v_o,
  output logic [vtag_width_p-1:0]     walk_vtag_o,
  input  logic                        walk_ready_i,
  input  logic                        walk_done_v_i,
  input  logic [entry_width_p-1:0]    walk_entry_i,
  input  logic                        walk_fault_i,
  output logic [1:0]                  fill_v_o,
  output logic [vtag_width_p-1:0]     fill_vtag_o,
  output logic [entry_width_p-1:0]    fill_entry_o,
  output logic [1:0]                  fault_v_o,
  output logic [1:0]                  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FILL = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic                       poison_q, poison_d;
  // Side that won the last contested grant: 0 = I, 1 = D.
  logic                       last_grant_q, last_grant_d;
  // One-hot (or both, when merged) mask of the sides the current walk serves.
  logic [1:0]                 req_mask_q, req_mask_d;
  logic [vtag_width_p-1:0]    vtag_q, vtag_d;
  logic [entry_width_p-1:0]   entry_q, entry_d;
  logic                       fault_q, fault_d;

  logic [vtag_width_p-1:0]    vtag_i_side;
  logic [vtag_width_p-1:0]    vtag_d_side;
  logic [1:0]                 grant;
  logic [1:0]                 accept;
  logic                       fill_ok;
  logic                       fault_ok;

  assign vtag_i_side = miss_vtag_i[vtag_width_p-1:0];
  assign vtag_d_side = miss_vtag_i[2*vtag_width_p-1:vtag_width_p];

  // ---------------------------------------------------------------------------
  // Round-robin grant. A lone requester always wins; on a tie the side that
  // did not win last time is chosen.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant = 2'b00;
    case (miss_v_i)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
`ifdef BP_MMU_FILL_DEDUP_EN
    // Same page missed on both sides: serve both with one walk.
    if ((miss_v_i == 2'b11) && (vtag_i_side == vtag_d_side)) begin
      grant = 2'b11;
    end
`endif
  end

  // A flush in IDLE blocks acceptance so no new walk starts against a stale
  // translation context.
  assign accept = grant & {2{~flush_i}};

  // FILL strobes are suppressed by a flush seen during the walk (poison) or
  // by a flush in the FILL cycle itself.
  assign fill_ok  = ~fault_q & ~poison_q & ~flush_i;
  assign fault_ok =  fault_q & ~poison_q & ~flush_i;

  // ---------------------------------------------------------------------------
  // Next-state and output decode.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    poison_d     = poison_q;
    last_grant_d = last_grant_q;
    req_mask_d   = req_mask_q;
    vtag_d       = vtag_q;
    entry_d      = entry_q;
    fault_d      = fault_q;
    miss_ready_o = 2'b00;
    walk_v_o     = 1'b0;
    fill_v_o     = 2'b00;
    fault_v_o    = 2'b00;

    case (state_q)
      S_IDLE: begin
        miss_ready_o = accept;
        poison_d     = 1'b0;
        if (accept != 2'b00) begin
          req_mask_d = accept;
          vtag_d     = accept[0] ? vtag_i_side : vtag_d_side;
          // A merged grant served both sides, so fairness is unaffected.
          if (accept != 2'b11) begin
            last_grant_d = accept[1];
          end
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        walk_v_o = 1'b1;
        if (flush_i) begin
          poison_d = 1'b1;
        end
        if (walk_ready_i) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // The PTW cannot be cancelled; a flushed walk is allowed to finish and
        // its result is simply dropped in FILL.
        if (flush_i) begin
          poison_d = 1'b1;
        end
        if (walk_done_v_i) begin
          entry_d = walk_entry_i;
          fault_d = walk_fault_i;
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        fill_v_o  = req_mask_q & {2{fill_ok}};
        fault_v_o = req_mask_q & {2{fault_ok}};
        poison_d  = 1'b0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      poison_q     <= 1'b0;
      last_grant_q <= 1'b1;
      req_mask_q   <= 2'b00;
      vtag_q       <= '0;
      entry_q      <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      poison_q     <= poison_d;
      last_grant_q <= last_grant_d;
      req_mask_q   <= req_mask_d;
      vtag_q       <= vtag_d;
      entry_q      <= entry_d;
      fault_q      <= fault_d;
    end
  end

  // The latched vtag feeds both the walk request and the TLB write, so both
  // are stable for the whole transaction.
  assign walk_vtag_o  = vtag_q;
  assign fill_vtag_o  = vtag_q;
  assign fill_entry_o = entry_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_bp_mmu_fill_sched.sv
module tb_bp_mmu_fill_sched;

  localparam int VW = 27;
  localparam int EW = 36;
  localparam int N_ROWS = 9;
  localparam int N_RAND = 3000;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic            clk;
  logic            reset_n;
  logic            flush;
  logic [1:0]      miss_v;
  logic [2*VW-1:0] miss_vtag;
  logic [1:0]      miss_ready;
  logic            walk_v;
  logic [VW-1:0]   walk_vtag;
  logic            walk_ready;
  logic            walk_done;
  logic [EW-1:0]   walk_entry;
  logic            walk_fault;
  logic [1:0]      fill_v;
  logic [VW-1:0]   fill_vtag;
  logic [EW-1:0]   fill_entry;
  logic [1:0]      fault_v;
  logic [1:0]      dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bp_mmu_fill_sched #(.vtag_width_p(VW), .entry_width_p(EW)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .flush_i      (flush),
    .miss_v_i     (miss_v),
    .miss_vtag_i  (miss_vtag),
    .miss_ready_o (miss_ready),
    .walk_v_o     (walk_v),
    .walk_vtag_o  (walk_vtag),
    .walk_ready_i (walk_ready),
    .walk_done_v_i(walk_done),
    .walk_entry_i (walk_entry),
    .walk_fault_i (walk_fault),
    .fill_v_o     (fill_v),
    .fill_vtag_o  (fill_vtag),
    .fill_entry_o (fill_entry),
    .fault_v_o    (fault_v),
    .dbg_state_o  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arbitration rule as stated for the block: a lone requester wins, a tie
  // goes to the side that did not win last; equal vtags merge when dedup is on.
  function automatic logic [1:0] arb(input logic [1:0] v, input logic [VW-1:0] a,
                                     input logic [VW-1:0] b, input bit last_d);
    if (v == 2'b11) begin
`ifdef BP_MMU_FILL_DEDUP_EN
      if (a == b) return 2'b11;
`endif
      return last_d ? 2'b01 : 2'b10;
    end
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed transaction table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]    mv;
    logic [VW-1:0] v0;
    logic [VW-1:0] v1;
    int            d;        // cycles walk_ready held low in REQ
    int            lat;      // cycles from walk handshake to done (>=1)
    int            flush_t;  // cycle index to pulse flush, 0 = none
    logic [EW-1:0] entry;
    logic          fault;
    logic [1:0]    e_rdy;
    logic [1:0]    e_fill;
    logic [1:0]    e_fault;
    logic [VW-1:0] e_vtag;
  } row_t;

  row_t rows[N_ROWS];

  function automatic row_t mk(input logic [1:0] mv, input logic [VW-1:0] v0, input logic [VW-1:0] v1,
                              input int d, input int lat, input int ft, input logic [EW-1:0] e,
                              input logic f, input logic [1:0] er, input logic [1:0] ef,
                              input logic [1:0] eflt, input logic [VW-1:0] ev);
    row_t r;
    r.mv = mv; r.v0 = v0; r.v1 = v1; r.d = d; r.lat = lat; r.flush_t = ft;
    r.entry = e; r.fault = f; r.e_rdy = er; r.e_fill = ef; r.e_fault = eflt; r.e_vtag = ev;
    return r;
  endfunction

  task automatic drive_quiet();
    flush = 1'b0; miss_v = 2'b00; miss_vtag = '0;
    walk_ready = 1'b0; walk_done = 1'b0; walk_entry = '0; walk_fault = 1'b0;
  endtask

  // One full transaction: present request, check grant, run the PTW with the
  // row's timing and check walk and fill outputs every cycle. Accept happens
  // at the edge ending cycle 0; fill is due 2 + d + lat cycles later.
  task automatic run_row(input row_t r, input int idx);
    int tf;
    logic [63:0] rnd;
    tf = 2 + r.d + r.lat;
    @(negedge clk);
    drive_quiet();
    miss_v = r.mv;
    miss_vtag = {r.v1, r.v0};
    #1 chk($sformatf("row%0d_ready", idx), miss_ready, r.e_rdy);
    for (int t = 1; t <= tf; t++) begin
      @(negedge clk);
      rnd = {$urandom, $urandom};
      miss_v = 2'b00;
      walk_ready = (t == 1 + r.d);
      walk_done  = (t == 1 + r.d + r.lat);
      walk_entry = walk_done ? r.entry : rnd[EW-1:0];
      walk_fault = walk_done ? r.fault : rnd[63];
      flush = (t == r.flush_t);
      #1;
      chk($sformatf("row%0d_t%0d_walk_v", idx, t), walk_v, (t <= 1 + r.d));
      if (t <= 1 + r.d) chk($sformatf("row%0d_t%0d_walk_vtag", idx, t), walk_vtag, r.e_vtag);
      chk($sformatf("row%0d_t%0d_fill_v", idx, t), fill_v, (t == tf) ? r.e_fill : 2'b00);
      chk($sformatf("row%0d_t%0d_fault_v", idx, t), fault_v, (t == tf) ? r.e_fault : 2'b00);
      if (t == tf && r.e_fill != 2'b00) begin
        chk($sformatf("row%0d_fill_vtag", idx), fill_vtag, r.e_vtag);
        chk($sformatf("row%0d_fill_entry", idx), fill_entry, r.entry);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Randomized run with a transaction-level reference model
  // ---------------------------------------------------------------------------
  bit            pend[2];
  logic [VW-1:0] rv[2];
  bit            m_last;
  bit            live;
  int            t_acc, t_hs, t_done, ptw_cnt;
  logic [1:0]    t_mask;
  logic [VW-1:0] t_vtag;
  bit            t_poison, t_fault;

  task automatic run_random();
    bit req_ph, wait_ph, fill_ph, idle;
    logic [1:0] e_rdy, e_fill, e_fault;
    logic [EW-1:0] e_entry;
    logic [63:0] rnd;
    pend[0] = 0; pend[1] = 0; rv[0] = '0; rv[1] = '0;
    m_last = 1'b1; live = 0; t_acc = 0; t_hs = -1; t_done = -1; ptw_cnt = 0;
    t_mask = 2'b00; t_vtag = '0; t_poison = 0; t_fault = 0;
    for (int cyc = 0; cyc < N_RAND; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          rnd = {$urandom, $urandom};
          pend[i] = 1;
          rv[i] = ($urandom_range(0, 1) == 1) ? VW'($urandom_range(0, 3)) : rnd[VW-1:0];
        end
      end
      miss_v    = {pend[1], pend[0]};
      miss_vtag = {rv[1], rv[0]};
      flush     = ($urandom_range(0, 15) == 0);
      idle    = !live;
      req_ph  = live && cyc > t_acc && t_hs < 0;
      wait_ph = live && t_hs >= 0 && t_done < 0 && cyc > t_hs;
      fill_ph = live && t_done >= 0 && cyc == t_done + 1;
      walk_ready = ($urandom_range(0, 1) == 1);
      walk_done  = wait_ph ? (ptw_cnt == 0) : ($urandom_range(0, 7) == 0);
      rnd = {$urandom, $urandom};
      walk_entry = rnd[EW-1:0];
      walk_fault = ($urandom_range(0, 3) == 0);
      e_rdy = (idle && !flush) ? arb(miss_v, rv[0], rv[1], m_last) : 2'b00;
      #1;
      chk("rnd_miss_ready", miss_ready, e_rdy);
      chk("rnd_walk_v", walk_v, req_ph);
      if (req_ph) chk("rnd_walk_vtag", walk_vtag, t_vtag);
      if (fill_ph) begin
        e_fill  = (!t_fault && !t_poison && !flush) ? t_mask : 2'b00;
        e_fault = ( t_fault && !t_poison && !flush) ? t_mask : 2'b00;
        e_entry = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk("rnd_fill_v", fill_v, e_fill);
        chk("rnd_fault_v", fault_v, e_fault);
        if (e_fill != 2'b00) begin
          chk("rnd_fill_vtag", fill_vtag, t_vtag);
          chk("rnd_fill_entry", fill_entry, e_entry);
        end
      end else begin
        chk("rnd_fill_v_idle", fill_v, 2'b00);
        chk("rnd_fault_v_idle", fault_v, 2'b00);
      end
      // model update for the coming clock edge
      if (fill_ph) live = 0;
      else if (live && cyc > t_acc && flush) t_poison = 1;
      if (req_ph && walk_ready) begin
        t_hs = cyc;
        ptw_cnt = $urandom_range(0, 3);
      end
      if (wait_ph) begin
        if (walk_done) begin
          t_done = cyc;
          t_fault = walk_fault;
          exp_q.push_back(walk_entry);
        end else begin
          ptw_cnt--;
        end
      end
      if (idle && e_rdy != 2'b00) begin
        live = 1; t_acc = cyc; t_hs = -1; t_done = -1; t_poison = 0;
        t_mask = e_rdy;
        t_vtag = e_rdy[0] ? rv[0] : rv[1];
        if (e_rdy != 2'b11) m_last = e_rdy[1];
        if (e_rdy[0]) pend[0] = 0;
        if (e_rdy[1]) pend[1] = 0;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rows[0] = mk(2'b11, 'h10, 'h20, 0, 1, 0, 'h111, 0, 2'b01, 2'b01, 2'b00, 'h10);
    rows[1] = mk(2'b11, 'h10, 'h20, 0, 1, 0, 'h222, 0, 2'b10, 2'b10, 2'b00, 'h20);
    rows[2] = mk(2'b11, 'h10, 'h20, 0, 2, 0, 'h333, 0, 2'b01, 2'b01, 2'b00, 'h10);
    rows[3] = mk(2'b10, 'h0, 'h1234, 0, 1, 0, 'hABC, 0, 2'b10, 2'b10, 2'b00, 'h1234);
    rows[4] = mk(2'b01, 'h77, 'h0, 0, 1, 0, 'h444, 1, 2'b01, 2'b00, 2'b01, 'h77);
    rows[5] = mk(2'b10, 'h0, 'h88, 0, 6, 2, 'h555, 0, 2'b10, 2'b00, 2'b00, 'h88);
    rows[6] = mk(2'b01, 'h3ff, 'h0, 10, 2, 0, 'h123, 0, 2'b01, 2'b01, 2'b00, 'h3ff);
`ifdef BP_MMU_FILL_DEDUP_EN
    rows[7] = mk(2'b11, 'h55, 'h55, 0, 1, 0, 'h5a5, 0, 2'b11, 2'b11, 2'b00, 'h55);
    rows[8] = mk(2'b11, 'h55, 'h55, 0, 1, 0, 'h666, 0, 2'b11, 2'b11, 2'b00, 'h55);
`else
    rows[7] = mk(2'b11, 'h55, 'h55, 0, 1, 0, 'h5a5, 0, 2'b10, 2'b10, 2'b00, 'h55);
    rows[8] = mk(2'b11, 'h55, 'h55, 0, 1, 0, 'h666, 0, 2'b01, 2'b01, 2'b00, 'h55);
`endif

    // Reset state: outputs quiet, grant visible combinationally, I wins tie.
    drive_quiet();
    reset_n = 1'b0;
    miss_v = 2'b11;
    miss_vtag = {VW'('h20), VW'('h10)};
    repeat (2) @(negedge clk);
    #1;
    chk("reset_walk_v", walk_v, 1'b0);
    chk("reset_fill_v", fill_v, 2'b00);
    chk("reset_fault_v", fault_v, 2'b00);
    chk("reset_fill_vtag", fill_vtag, '0);
    chk("reset_fill_entry", fill_entry, '0);
    chk("reset_ready_tie", miss_ready, 2'b01);
    chk("reset_state_idle", dbg_state, 2'd0);
    @(negedge clk);
    drive_quiet();
    reset_n = 1'b1;

    for (int i = 0; i < N_ROWS; i++) run_row(rows[i], i);

    // Spurious done while idle must be ignored.
    @(negedge clk);
    drive_quiet();
    walk_done = 1'b1; walk_entry = 'h999; walk_fault = 1'b0;
    #1 chk("spur_walk_v", walk_v, 1'b0);
    @(negedge clk);
    drive_quiet();
    #1;
    chk("spur_fill_v", fill_v, 2'b00);
    chk("spur_fault_v", fault_v, 2'b00);
    chk("spur_walk_v2", walk_v, 1'b0);

    // Flush in IDLE blocks acceptance; ready returns once flush drops.
    @(negedge clk);
    drive_quiet();
    miss_v = 2'b01; miss_vtag = {VW'(0), VW'('h42)}; flush = 1'b1;
    #1 chk("idle_flush_ready", miss_ready, 2'b00);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("idle_noflush_ready", miss_ready, 2'b01);
    miss_v = 2'b00;
    @(negedge clk);
    #1 chk("idle_noflush_walk_v", walk_v, 1'b0);

    // Reset in the middle of a walk returns to IDLE with strobes low.
    @(negedge clk);
    drive_quiet();
    miss_v = 2'b10; miss_vtag = {VW'('h321), VW'(0)};
    @(negedge clk);
    miss_v = 2'b00;
    #1 chk("midrst_walk_v_before", walk_v, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst_walk_v", walk_v, 1'b0);
    chk("midrst_fill_v", fill_v, 2'b00);
    chk("midrst_fault_v", fault_v, 2'b00);
    miss_v = 2'b11;
    #1 chk("midrst_ready_tie", miss_ready, 2'b01);
    @(negedge clk);
    drive_quiet();
    reset_n = 1'b1;

    run_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
